// File: rtl/div_iterative_core_pkg.sv
// Shared divider types: FIFO entry layout, per-op attributes and core FSM states.
package div_iterative_core_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CLZ_W = 5;
  localparam int unsigned ID_W  = 3;

  typedef logic [ID_W-1:0] id_t;

  typedef struct packed {
    logic remainder_op;
    logic negate_result;
    logic reuse_result;
    id_t  id;
  } div_attributes_t;

  typedef struct packed {
    logic [XLEN-1:0]  unsigned_dividend;
    logic [XLEN-1:0]  unsigned_divisor;
    logic [CLZ_W-1:0] dividend_CLZ;
    logic [CLZ_W-1:0] divisor_CLZ;
    logic             divisor_is_zero;
    div_attributes_t  attr;
  } div_fifo_inputs_t;

  typedef enum logic [1:0] {
    DIV_IDLE,
    DIV_COMPUTE,
    DIV_DONE
  } div_state_t;

endpackage

// File: rtl/div_iterative_core_if.sv
// Divider core bus: input FIFO read side plus writeback valid/ack.
interface div_iterative_core_if;
  import div_iterative_core_pkg::*;

  logic             fifo_valid;
  div_fifo_inputs_t fifo_data;
  logic             fifo_pop;
  logic             wb_valid;
  id_t              wb_id;
  logic [XLEN-1:0]  wb_data;
  logic             wb_ack;
  logic             busy;

  modport master (
    input  fifo_valid, fifo_data, wb_ack,
    output fifo_pop, wb_valid, wb_id, wb_data, busy
  );

  modport slave (
    output fifo_valid, fifo_data, wb_ack,
    input  fifo_pop, wb_valid, wb_id, wb_data, busy
  );
endinterface

// File: rtl/div_iterative_core_result_select.sv
// Picks quotient or remainder and applies optional two's-complement negation.
module div_iterative_core_result_select
  import div_iterative_core_pkg::*;
(
  input  logic [XLEN-1:0] q_i,
  input  logic [XLEN-1:0] r_i,
  input  logic            remainder_op_i,
  input  logic            negate_i,
  output logic [XLEN-1:0] data_o
);
  logic [XLEN-1:0] sel;

  assign sel    = remainder_op_i ? r_i : q_i;
  assign data_o = (sel ^ {XLEN{negate_i}}) + XLEN'(negate_i);
endmodule

// File: rtl/div_iterative_core.sv
// Iterative unsigned radix-2 restoring divider fed from the divider FIFO, with
// CLZ-based iteration skipping, result reuse and a valid/ack writeback port.
module div_iterative_core
  import div_iterative_core_pkg::*;
#(
  parameter bit ENABLE_CLZ_SKIP = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  div_iterative_core_if.master core_io
);
  localparam int unsigned DW = 2 * XLEN - 1;

  div_state_t       state_q, state_d;
  logic [XLEN-1:0]  q_q, r_q, last_q_q, last_r_q, wb_data_q;
  logic [DW-1:0]    d_q;
  logic [CLZ_W-1:0] counter_q;
  logic             rem_op_q, negate_q;
  id_t              id_q, wb_id_q;

  logic             pop_c, load_c, done_entry_c, fast_path_c, ge_c;
  logic [CLZ_W-1:0] shift_c;
  logic [XLEN-1:0]  q_iter_c, r_iter_c, fin_q_c, fin_r_c, result_c;
  logic             sel_rem_c, sel_neg_c;
  id_t              sel_id_c;

  div_fifo_inputs_t entry;
  assign entry = core_io.fifo_data;

  assign fast_path_c = entry.attr.reuse_result | entry.divisor_is_zero |
                       (ENABLE_CLZ_SKIP && (entry.dividend_CLZ > entry.divisor_CLZ));
  assign shift_c     = ENABLE_CLZ_SKIP ? (entry.divisor_CLZ - entry.dividend_CLZ)
                                       : CLZ_W'(XLEN - 1);

  // One restoring step on the current working registers
  assign ge_c     = {{(XLEN-1){1'b0}}, r_q} >= d_q;
  assign r_iter_c = ge_c ? (r_q - d_q[XLEN-1:0]) : r_q;
  assign q_iter_c = {q_q[XLEN-2:0], ge_c};

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= DIV_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      DIV_IDLE:    if (core_io.fifo_valid) state_d = fast_path_c ? DIV_DONE : DIV_COMPUTE;
      DIV_COMPUTE: if (counter_q == '0) state_d = DIV_DONE;
      DIV_DONE:    if (core_io.wb_ack) state_d = DIV_IDLE;
      default:     state_d = DIV_IDLE;
    endcase
  end

  // FSM control outputs
  always_comb begin
    pop_c        = 1'b0;
    load_c       = 1'b0;
    done_entry_c = 1'b0;
    unique case (state_q)
      DIV_IDLE: begin
        pop_c        = core_io.fifo_valid;
        load_c       = core_io.fifo_valid & ~fast_path_c;
        done_entry_c = core_io.fifo_valid & fast_path_c;
      end
      DIV_COMPUTE: done_entry_c = (counter_q == '0);
      default: ;
    endcase
  end

  // Raw q/r and attributes seen on the cycle that enters DONE
  always_comb begin
    fin_q_c   = q_iter_c;
    fin_r_c   = r_iter_c;
    sel_rem_c = rem_op_q;
    sel_neg_c = negate_q;
    sel_id_c  = id_q;
    if (state_q == DIV_IDLE) begin
      sel_rem_c = entry.attr.remainder_op;
      sel_neg_c = entry.attr.negate_result;
      sel_id_c  = entry.attr.id;
      if (entry.attr.reuse_result) begin
        fin_q_c = last_q_q;
        fin_r_c = last_r_q;
      end else if (entry.divisor_is_zero) begin
        fin_q_c = '1;
        fin_r_c = entry.unsigned_dividend;
      end else begin
        fin_q_c = '0;
        fin_r_c = entry.unsigned_dividend;
      end
    end
  end

  div_iterative_core_result_select u_result_select (
    .q_i            (fin_q_c),
    .r_i            (fin_r_c),
    .remainder_op_i (sel_rem_c),
    .negate_i       (sel_neg_c),
    .data_o         (result_c)
  );

  // Datapath and writeback registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q       <= '0;
      r_q       <= '0;
      d_q       <= '0;
      counter_q <= '0;
      rem_op_q  <= 1'b0;
      negate_q  <= 1'b0;
      id_q      <= '0;
      last_q_q  <= '0;
      last_r_q  <= '0;
      wb_data_q <= '0;
      wb_id_q   <= '0;
    end else begin
      if (load_c) begin
        d_q       <= DW'(entry.unsigned_divisor) << shift_c;
        r_q       <= entry.unsigned_dividend;
        q_q       <= '0;
        counter_q <= shift_c;
        rem_op_q  <= entry.attr.remainder_op;
        negate_q  <= entry.attr.negate_result;
        id_q      <= entry.attr.id;
      end else if (state_q == DIV_COMPUTE) begin
        d_q <= d_q >> 1;
        r_q <= r_iter_c;
        q_q <= q_iter_c;
        if (counter_q != '0) counter_q <= counter_q - CLZ_W'(1);
      end
      if (done_entry_c) begin
        last_q_q  <= fin_q_c;
        last_r_q  <= fin_r_c;
        wb_data_q <= result_c;
        wb_id_q   <= sel_id_c;
      end
    end
  end

  assign core_io.fifo_pop = pop_c;
  assign core_io.wb_valid = (state_q == DIV_DONE);
  assign core_io.busy     = (state_q != DIV_IDLE);
  assign core_io.wb_data  = wb_data_q;
  assign core_io.wb_id    = wb_id_q;

endmodule
